// File: rtl/fetch_pkg.sv
// Shared widths, constants and offset sign-extension helpers for the
// prefetching instruction-fetch unit.
package fetch_pkg;

  localparam int XLEN_DEF = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [XLEN_DEF-1:0] RESET_PC_DEF = '0;

  function automatic logic [XLEN_DEF-1:0] sext16(input logic [15:0] v);
    return {{(XLEN_DEF-16){v[15]}}, v};
  endfunction

  function automatic logic [XLEN_DEF-1:0] sext26(input logic [25:0] v);
    return {{(XLEN_DEF-26){v[25]}}, v};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: DEPTH x W synchronous FIFO; flush wins over push and pop.
module fetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  input  logic          flush,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_q];
  assign count   = cnt_q;

  // Storage is reset so the head reads as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din;
        wr_q        <= wr_q + AW'(1);
      end
      if (do_pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/inst_fetch_pf.sv
// Prefetching fetch unit: credit-limited request issue, in-order response
// capture into the prefetch buffer, and redirect flush with stale-drop count.
module inst_fetch_pf
  import fetch_pkg::*;
#(
  parameter int               XLEN     = XLEN_DEF,
  parameter int               DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redir_jmp_r,
  input  logic            redir_branch,
  input  logic            redir_jmp,
  input  logic [XLEN-1:0] redir_pc,
  input  logic [15:0]     imm16,
  input  logic [25:0]     jmp_imm26,
  input  logic [XLEN-1:0] reg_imm32,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [XLEN-1:0] STEP = XLEN'(INSTR_BYTES);

  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]     outst_q, outst_d;
  logic [CW-1:0]     drop_q, drop_d;
  logic [XLEN-1:0]   target;
  logic              redir_any, credit, req_fire, rsp_keep;
  logic [CW-1:0]     fifo_cnt;
  logic              fifo_full, fifo_empty;
  logic [2*XLEN-1:0] fifo_dout;

  assign redir_any = redir_jmp_r || redir_branch || redir_jmp;
  assign target    = redir_jmp_r  ? reg_imm32 :
                     redir_branch ? redir_pc + XLEN'($signed(sext16(imm16))) :
                                    redir_pc + XLEN'($signed(sext26(jmp_imm26)));

  // Every in-flight request owns a buffer slot, so responses can never overflow.
  assign credit         = ({1'b0, outst_q} + {1'b0, fifo_cnt}) < (CW+1)'(DEPTH);
  assign imem_req_valid = reset && !redir_any && credit;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_keep       = imem_rsp_valid && (drop_q == '0) && !redir_any;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    drop_d     = drop_q;
    outst_d    = outst_q + CW'(req_fire) - CW'(imem_rsp_valid);
    if (redir_any) begin
      fetch_pc_d = target;
      rsp_pc_d   = target;
      drop_d     = outst_d;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + STEP;
      if (rsp_keep) rsp_pc_d = rsp_pc_q + STEP;
      if (imem_rsp_valid && drop_q != '0) drop_d = drop_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  fetch_fifo #(.W(2*XLEN), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (rsp_keep && !fifo_full),
    .din   ({rsp_pc_q, imem_rsp_data}),
    .pop   (out_valid && out_ready && !redir_any),
    .flush (redir_any),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  assign out_valid     = !fifo_empty;
  assign out_pc        = fifo_dout[2*XLEN-1:XLEN];
  assign out_instr     = fifo_dout[XLEN-1:0];
  assign imem_req_addr = fetch_pc_q;
  assign pc            = fetch_pc_q;

endmodule

// File: tb/tb_inst_fetch_pf.sv
// Directed bench for inst_fetch_pf: redirect target table plus hand-written
// streaming, backpressure, stale-drop and async-reset sequences.
module tb_inst_fetch_pf;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        redir_jmp_r = 1'b0, redir_branch = 1'b0, redir_jmp = 1'b0;
  logic [31:0] redir_pc = '0, reg_imm32 = '0;
  logic [15:0] imm16 = '0;
  logic [25:0] jmp_imm26 = '0;
  logic        imem_req_valid, imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        out_valid, out_ready = 1'b1;
  logic [31:0] out_pc, out_instr, pc;

  inst_fetch_pf dut (
    .clk(clk), .reset(reset),
    .redir_jmp_r(redir_jmp_r), .redir_branch(redir_branch), .redir_jmp(redir_jmp),
    .redir_pc(redir_pc), .imm16(imm16), .jmp_imm26(jmp_imm26), .reg_imm32(reg_imm32),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .pc(pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hC0DE_5A5A;
  endfunction

  // Instruction memory with a configurable fixed latency of 1..4 cycles.
  int          lat = 1;
  logic [3:0]  pv = '0;
  logic [31:0] pa [4];
  logic        mf;
  logic [31:0] ma;
  always begin
    @(negedge clk);
    mf = imem_req_valid && imem_req_ready;
    ma = imem_req_addr;
    @(posedge clk);
    #1;
    for (int i = 3; i > 0; i--) begin
      pv[i] = pv[i-1];
      pa[i] = pa[i-1];
    end
    pv[0] = mf;
    pa[0] = ma;
    for (int i = 0; i < 4; i++) if (i >= lat) pv[i] = 1'b0;
    imem_rsp_valid = pv[lat-1];
    imem_rsp_data  = word(pa[lat-1]);
  end

  typedef struct {
    logic        jr, br, jp;
    logic [31:0] rpc;
    logic [15:0] i16;
    logic [25:0] i26;
    logic [31:0] rimm;
    logic [31:0] tgt;
  } vec_t;
  vec_t vt [10];

  int          nvec = 0, nerr = 0, nfire = 0, npop = 0;
  logic [31:0] exp_pc = '0, exp_tgt = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    nvec++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  // One clock: sample pre-edge outputs at the negedge, then step to edge+1.
  task automatic tick();
    @(negedge clk);
    if (imem_req_valid && imem_req_ready) nfire++;
    if (redir_jmp_r || redir_branch || redir_jmp) exp_pc = exp_tgt;
    else if (out_valid && out_ready) begin
      chk("pop_pc", out_pc, exp_pc);
      chk("pop_instr", out_instr, word(exp_pc));
      exp_pc += 32'd4;
      npop++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max);
    for (int i = 0; i < max; i++) begin
      if (out_valid) break;
      tick();
    end
    chk("wait_out_valid", {31'b0, out_valid}, 32'd1);
  endtask

  task automatic do_reset(input int l);
    reset = 1'b0;
    repeat (5) tick();
    lat = l;
    reset = 1'b1;
    exp_pc = 32'h0;
  endtask

  task automatic apply_redir(input vec_t v);
    redir_jmp_r = v.jr; redir_branch = v.br; redir_jmp = v.jp;
    redir_pc = v.rpc; imm16 = v.i16; jmp_imm26 = v.i26; reg_imm32 = v.rimm;
    exp_tgt = v.tgt;
    #1;
    chk("redir_no_req", {31'b0, imem_req_valid}, 32'd0);
    tick();
    redir_jmp_r = 1'b0; redir_branch = 1'b0; redir_jmp = 1'b0;
    #1;
    chk("redir_req_addr", imem_req_addr, v.tgt);
    chk("redir_pc_out", pc, v.tgt);
    chk("redir_out_valid", {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    vt[0] = '{1, 0, 0, 32'h0,         16'h0,    26'h0,       32'h1234_5678, 32'h1234_5678};
    vt[1] = '{1, 1, 0, 32'h100,       16'h10,   26'h0,       32'h2000,      32'h2000};
    vt[2] = '{0, 1, 0, 32'h100,       16'hFFF0, 26'h0,       32'h0,         32'hF0};
    vt[3] = '{0, 1, 0, 32'h1000,      16'h0040, 26'h0,       32'h0,         32'h1040};
    vt[4] = '{0, 0, 1, 32'hFFFF_FFF8, 16'h0,    26'h10,      32'h0,         32'h8};
    vt[5] = '{0, 0, 1, 32'h400,       16'h0,    26'h3FF_FFFC, 32'h0,        32'h3FC};
    vt[6] = '{0, 1, 1, 32'h200,       16'h8,    26'h100,     32'h0,         32'h208};
    vt[7] = '{1, 1, 1, 32'h500,       16'h4,    26'h40,      32'hABC0,      32'hABC0};
    vt[8] = '{1, 0, 1, 32'h0,         16'h0,    26'h1000,    32'h40,        32'h40};
    vt[9] = '{0, 1, 0, 32'h0001_0000, 16'h8000, 26'h0,       32'h0,         32'h8000};

    #2;
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);

    // Streaming from reset, L=1.
    do_reset(1);
    #1;
    chk("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("first_req_addr", imem_req_addr, 32'h0);
    tick();
    chk("second_req_addr", imem_req_addr, 32'h4);
    chk("no_early_valid", {31'b0, out_valid}, 32'd0);
    tick();
    chk("first_out_valid", {31'b0, out_valid}, 32'd1);
    chk("first_out_pc", out_pc, 32'h0);
    chk("first_out_instr", out_instr, word(32'h0));
    repeat (8) begin
      tick();
      chk("sustained_valid", {31'b0, out_valid}, 32'd1);
    end

    // Backpressure: exactly DEPTH requests, then resume in order.
    out_ready = 1'b0;
    do_reset(1);
    nfire = 0;
    repeat (10) tick();
    chk("bp_fires", nfire, 32'd4);
    chk("bp_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
    chk("bp_count", 32'(dut.u_fifo.cnt_q), 32'd4);
    out_ready = 1'b1;
    npop = 0;
    repeat (10) tick();
    chk("bp_pops", npop, 32'd10);

    // Redirect target table, L=1 stream running.
    do_reset(1);
    repeat (5) tick();
    for (int k = 0; k < 10; k++) begin
      apply_redir(vt[k]);
      repeat (4) tick();
    end

    // L=3: branch with exactly three stale requests in flight.
    out_ready = 1'b0;
    do_reset(3);
    repeat (4) tick();
    chk("l3_outstanding", 32'(dut.outst_q), 32'd3);
    out_ready = 1'b1;
    apply_redir(vt[2]);
    wait_valid(20);
    chk("l3_first_pc", out_pc, 32'hF0);
    chk("l3_first_instr", out_instr, word(32'hF0));
    repeat (8) tick();

    // Back-to-back redirects: only the last target survives.
    redir_jmp_r = 1'b1; reg_imm32 = 32'h3000; exp_tgt = 32'h3000;
    tick();
    reg_imm32 = 32'h5000; exp_tgt = 32'h5000;
    tick();
    redir_jmp_r = 1'b0;
    #1;
    chk("b2b_req_addr", imem_req_addr, 32'h5000);
    wait_valid(20);
    chk("b2b_first_pc", out_pc, 32'h5000);
    repeat (6) tick();

    // Async reset mid-stream with responses still in flight.
    #3;
    reset = 1'b0;
    #1;
    chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("arst_out_pc", out_pc, 32'h0);
    chk("arst_out_instr", out_instr, 32'h0);
    chk("arst_pc", pc, 32'h0);
    repeat (5) begin
      tick();
      chk("arst_hold_valid", {31'b0, out_valid}, 32'd0);
    end
    reset = 1'b1;
    exp_pc = 32'h0;
    #1;
    chk("arst_restart_addr", imem_req_addr, 32'h0);
    chk("arst_restart_valid", {31'b0, out_valid}, 32'd0);
    wait_valid(20);
    chk("arst_first_pc", out_pc, 32'h0);
    chk("arst_first_instr", out_instr, word(32'h0));
    repeat (6) tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/inst_fetch_pf.md
# inst_fetch_pf

Parametrised prefetching instruction-fetch unit for the pipelined core. It replaces the single-register fetch stage with a request/response instruction-memory port, up to DEPTH outstanding reads, and a DEPTH-entry prefetch buffer that feeds decode through a valid/ready handshake. Redirects (branch, jump, jump-register) arrive from execute. A redirect flushes the buffer and discards in-flight responses, so decode never sees wrong-path instructions.

## Interface
Parameters:
- XLEN, 32, address/data width
- DEPTH, 4, prefetch buffer entries and outstanding-request limit (power of two, ≥2)
- RESET_PC, 32'h0, fetch address after reset

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-low; one clock; all state returns to reset values while low
- redir_jmp_r  in  1  jump to reg_imm32
- redir_branch  in  1  branch to redir_pc + sext(imm16)
- redir_jmp  in  1  jump to redir_pc + sext(jmp_imm26)
- redir_pc  in  XLEN  PC of the redirecting instruction
- imm16  in  16  branch byte offset
- jmp_imm26  in  26  jump byte offset
- reg_imm32  in  XLEN  register-file target
- imem_req_valid  out  1  read request
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  read address
- imem_rsp_valid  in  1  in-order read data valid; always accepted
- imem_rsp_data  in  XLEN  instruction word
- out_valid  out  1  buffer head valid
- out_ready  in  1  decode accepts head
- out_pc  out  XLEN  PC of head instruction
- out_instr  out  XLEN  head instruction
- pc  out  XLEN  next fetch address (= imem_req_addr)

## Operation
- State:
  - fetch_pc: next request address
  - rsp_pc: PC of the next valid response
  - outstanding: 0..DEPTH
  - drop_cnt: 0..DEPTH
  - buffer: entries of {pc, instr}, count 0..DEPTH
- Target priority: jmp_r > branch > jmp; only the highest asserted redirect is used.
- Target arithmetic: sign-extend the offset to XLEN, add modulo 2^XLEN, no shift, carry and overflow ignored.
- Issue:
  - imem_req_valid = !redir_any && (outstanding + count < DEPTH)
  - on handshake: fetch_pc += 4, outstanding += 1
- Response:
  - outstanding −1 for every response.
  - If drop_cnt > 0: drop_cnt −1, data discarded.
  - Else: push {rsp_pc, data} and rsp_pc += 4. The credit rule guarantees the buffer never overflows.
- Pop: out_valid && out_ready. Push and pop in the same cycle with count unchanged is legal, including at count=DEPTH−1 and count=1.
- Redirect cycle (redir_any=1):
  - no request issued
  - at the edge: fetch_pc and rsp_pc load the target, buffer count clears, pop ignored
  - any response arriving this cycle is discarded
  - drop_cnt ← outstanding − rsp_valid (the outstanding count before this edge) + drop_cnt − (rsp_valid && drop_cnt>0) … simplified: drop_cnt ← outstanding_next, i.e. all still-pending requests are stale
- Back-to-back redirects: each reloads the target; drop_cnt stays equal to outstanding.
- Reset (async low):
  - fetch_pc = rsp_pc = RESET_PC
  - outstanding = drop_cnt = count = 0
  - out_valid = 0, imem_req_valid = 0
  - out_pc / out_instr = 0
- After release, requests start on the first edge.
- Responses arriving while reset is asserted are ignored.

## Timing
- Request at edge t, response at t+L (L≥1). out_valid rises at edge t+L+1, i.e. two cycles minimum request-to-decode.
- Sustained one instruction/cycle when DEPTH ≥ L+1 and out_ready=1.
- Redirect asserted in cycle r:
  - no request in cycle r
  - first target request in cycle r+1
  - out_valid=0 in cycle r+1
- All outputs are registered or derived from registered state only, except imem_req_valid, which also depends combinationally on the redir_* inputs.

## Structure
- Package fetch_pkg: XLEN default, INSTR_BYTES=4, RESET_PC default, and the function sext16/sext26 → XLEN.
- Sub-module fetch_fifo: synchronous DEPTH×(2·XLEN) FIFO.
  - Ports: push, pop, flush, full, empty, count.
  - Flush has priority over push and pop.
  - Reset is async active-low.
- Top level holds the counters, target select, and credit logic.

## Test plan
- Reset release, L=1, out_ready=1:
  - requests to 0x0, 0x4, 0x8…
  - out_pc 0x0 appears two cycles after the first request
  - then one instruction per cycle
- out_ready=0 for 10 cycles, DEPTH=4, L=1:
  - exactly 4 requests issued, then imem_req_valid=0
  - count=4
  - resume yields PCs in order with no loss or duplication
- L=3, DEPTH=4, branch with redir_pc=0x100, imm16=0xFFF0 while 3 requests are outstanding:
  - next request is 0xF0
  - the 3 stale responses are dropped
  - first out_pc=0xF0
- redir_jmp_r and redir_branch both asserted, reg_imm32=0x2000:
  - target 0x2000
- jmp with redir_pc=0xFFFF_FFF8, jmp_imm26=0x10:
  - target wraps to 0x8
- reset pulled low mid-stream with a response pending:
  - all outputs cleared asynchronously
  - late response ignored
  - fetch restarts at RESET_PC
